// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
package pipeline_pkg;

    // Hazard sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        SQUASH   = 2'd2
    } hazard_state_t;

    // Encoding of addi x0,x0,0 loaded into IF/ID on a flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Register index width
    localparam int REG_IDX_W = 5;

    // True when a source operand is read and matches a non-x0 destination
    function automatic logic src_hazard(input logic                 use_rs,
                                        input logic [REG_IDX_W-1:0] rs,
                                        input logic [REG_IDX_W-1:0] rd);
        return use_rs && (rd != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with enable; holds at all-ones once full.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: increment when enabled unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional build macro HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_events performance counter outputs.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int FETCH_LATENCY = 1,
    parameter int MDU_TIMEOUT   = 64,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_useRs1,
    input  logic                 id_useRs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memRead,
    input  logic                 ex_branchTaken,
    input  logic                 ex_mduStart,
    input  logic                 mdu_done,
    input  logic                 mem_access,
    input  logic                 dmem_ready,
    output logic                 pcWrite,
    output logic                 IF_ID_Write,
    output logic                 IF_flush,
    output logic                 ID_EX_Write,
    output logic                 ID_EX_flush,
    output logic                 EX_MEM_Write,
    output logic                 EX_MEM_flush,
    output logic                 mdu_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
`endif
);

    localparam int SQ_W = (FETCH_LATENCY > 1) ? $clog2(FETCH_LATENCY + 1) : 1;
    localparam int MC_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT + 1) : 1;
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(FETCH_LATENCY);
    localparam logic [MC_W-1:0] MC_MAX  = MC_W'(MDU_TIMEOUT);

    hazard_state_t   state_q, state_d;
    logic [SQ_W-1:0] squash_cnt_q, squash_cnt_d;
    logic [MC_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic            mdu_timeout_q, mdu_timeout_d;

    logic mem_wait;
    logic load_use;
    logic mdu_stall;

    logic pc_write, if_id_write, if_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, ex_mem_flush;

    assign mem_wait  = mem_access && !dmem_ready;
    assign load_use  = ex_memRead && (src_hazard(id_useRs1, id_rs1, ex_rd) ||
                                      src_hazard(id_useRs2, id_rs2, ex_rd));
    // A busy MDU stalls unless its result arrives this cycle
    assign mdu_stall = (state_q == MDU_BUSY) && !mdu_done;

    // Prioritised hazard resolution: next state, counters and raw controls
    always_comb begin
        state_d       = state_q;
        squash_cnt_d  = squash_cnt_q;
        mdu_cnt_d     = mdu_cnt_q;
        mdu_timeout_d = mdu_timeout_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_flush      = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_flush  = 1'b0;

        if (mem_wait) begin
            // Whole pipeline frozen; sequencer state held as well
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (mdu_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            if (mdu_cnt_q != MC_MAX) begin
                mdu_cnt_d = mdu_cnt_q + 1'b1;
            end
            // Flag raised on the busy cycle that brings the count to the limit
            if (mdu_cnt_q >= MC_MAX - 1'b1) begin
                mdu_timeout_d = 1'b1;
            end
        end else if (ex_branchTaken) begin
            // Redirect: drop the instruction in ID and the one being fetched
            if_flush    = 1'b1;
            id_ex_flush = 1'b1;
            if (FETCH_LATENCY > 0) begin
                state_d      = SQUASH;
                squash_cnt_d = SQ_LOAD;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == SQUASH) begin
            // Wrong-path fetches still returning from instruction memory
            if_flush     = 1'b1;
            squash_cnt_d = squash_cnt_q - 1'b1;
            if (squash_cnt_q <= 1) begin
                state_d = RUN;
            end
        end else begin
            // Normal RUN cycle (also the cycle an MDU result returns)
            if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
            if (ex_mduStart) begin
                state_d   = MDU_BUSY;
                mdu_cnt_d = '0;
            end else begin
                state_d = RUN;
            end
        end
    end

    // Reset overrides every control: registers hold and load bubbles
    always_comb begin
        pcWrite      = pc_write     && !rst;
        IF_ID_Write  = if_id_write  && !rst;
        IF_flush     = if_flush     ||  rst;
        ID_EX_Write  = id_ex_write  && !rst;
        ID_EX_flush  = id_ex_flush  ||  rst;
        EX_MEM_Write = ex_mem_write && !rst;
        EX_MEM_flush = ex_mem_flush ||  rst;
    end

    // Sequencer state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            squash_cnt_q  <= '0;
            mdu_cnt_q     <= '0;
            mdu_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            squash_cnt_q  <= squash_cnt_d;
            mdu_cnt_q     <= mdu_cnt_d;
            mdu_timeout_q <= mdu_timeout_d;
        end
    end

    assign mdu_timeout = mdu_timeout_q;

    // Issuing an MDU op and redirecting in the same cycle is illegal
    a_no_mdu_with_branch: assert property (@(posedge clk) disable iff (rst)
        !(ex_mduStart && ex_branchTaken));

`ifdef HAZARD_PERF_CNT_EN
    logic stall_en;
    logic flush_en;

    assign stall_en = !rst && !pcWrite;
    assign flush_en = !rst && !mem_wait && ex_branchTaken;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_en),
        .count (stall_cycles)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_en),
        .count (flush_events)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (FETCH_LATENCY=2).
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_useRs1, id_useRs2, ex_memRead, ex_branchTaken, ex_mduStart;
    logic       mdu_done, mem_access, dmem_ready;
    logic       pcWrite, IF_ID_Write, IF_flush, ID_EX_Write, ID_EX_flush;
    logic       EX_MEM_Write, EX_MEM_flush, mdu_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int errors = 0;
    int checks = 0;

    // {pcWrite, IF_ID_Write, IF_flush, ID_EX_Write, ID_EX_flush, EX_MEM_Write, EX_MEM_flush}
    localparam logic [6:0] C_NORM   = 7'b1101010;
    localparam logic [6:0] C_RESET  = 7'b0010101;
    localparam logic [6:0] C_LDUSE  = 7'b0001110;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_SQUASH = 7'b1111010;
    localparam logic [6:0] C_MDU    = 7'b0000011;
    localparam logic [6:0] C_MEMW   = 7'b0000000;

    logic [6:0] ctl;
    assign ctl = {pcWrite, IF_ID_Write, IF_flush, ID_EX_Write, ID_EX_flush, EX_MEM_Write, EX_MEM_flush};

    pipeline_hazard_controller #(
        .FETCH_LATENCY (2),
        .MDU_TIMEOUT   (64),
        .CNT_W         (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_useRs1      (id_useRs1),
        .id_useRs2      (id_useRs2),
        .ex_rd          (ex_rd),
        .ex_memRead     (ex_memRead),
        .ex_branchTaken (ex_branchTaken),
        .ex_mduStart    (ex_mduStart),
        .mdu_done       (mdu_done),
        .mem_access     (mem_access),
        .dmem_ready     (dmem_ready),
        .pcWrite        (pcWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_flush       (IF_flush),
        .ID_EX_Write    (ID_EX_Write),
        .ID_EX_flush    (ID_EX_flush),
        .EX_MEM_Write   (EX_MEM_Write),
        .EX_MEM_flush   (EX_MEM_flush),
        .mdu_timeout    (mdu_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs are applied just after a rising edge; controls sampled on the falling edge
    task automatic run_cycle(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check(tag, {25'd0, ctl}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_useRs1 = 0; id_useRs2 = 0; ex_memRead = 0;
        ex_branchTaken = 0; ex_mduStart = 0; mdu_done = 0;
        mem_access = 0; dmem_ready = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", {25'd0, ctl}, {25'd0, C_RESET});
        check("reset_timeout", {31'd0, mdu_timeout}, 32'd0);
        rst = 1'b0;

        // T1 load-use
        ex_memRead = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_useRs1 = 1;
        run_cycle("t1_loaduse_rs1", C_LDUSE);
        ex_memRead = 0;
        run_cycle("t1_load_left", C_NORM);
        ex_memRead = 1; ex_rd = 5'd0; id_rs1 = 5'd0;
        run_cycle("t1_x0", C_NORM);
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_useRs2 = 1;
        run_cycle("t1_loaduse_rs2", C_LDUSE);
        id_useRs2 = 0;
        run_cycle("t1_rs2_unused", C_NORM);
        clear_inputs();

        // T2 taken branch with two wrong-path fetches
        ex_branchTaken = 1;
        run_cycle("t2_branch", C_BRANCH);
        ex_branchTaken = 0;
        run_cycle("t2_squash1", C_SQUASH);
        run_cycle("t2_squash2", C_SQUASH);
        run_cycle("t2_run", C_NORM);

        // T5 branch during SQUASH reloads the counter
        ex_branchTaken = 1;
        run_cycle("t5_branch_a", C_BRANCH);
        ex_branchTaken = 0;
        run_cycle("t5_squash_a", C_SQUASH);
        ex_branchTaken = 1;
        run_cycle("t5_branch_b", C_BRANCH);
        ex_branchTaken = 0;
        run_cycle("t5_reload1", C_SQUASH);
        run_cycle("t5_reload2", C_SQUASH);
        run_cycle("t5_run", C_NORM);

        // T5 branch wins over load-use
        ex_branchTaken = 1; ex_memRead = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_useRs1 = 1;
        run_cycle("t5_br_ldu", C_BRANCH);
        clear_inputs();
        run_cycle("t5_br_ldu_sq1", C_SQUASH);
        run_cycle("t5_br_ldu_sq2", C_SQUASH);
        run_cycle("t5_br_ldu_run", C_NORM);

        // T3 MDU op completing after 10 busy cycles
        ex_mduStart = 1;
        run_cycle("t3_start", C_NORM);
        ex_mduStart = 0;
        for (int i = 0; i < 10; i++) run_cycle($sformatf("t3_busy%0d", i), C_MDU);
        mdu_done = 1;
        run_cycle("t3_done", C_NORM);
        mdu_done = 0;
        run_cycle("t3_run", C_NORM);
        check("t3_no_timeout", {31'd0, mdu_timeout}, 32'd0);

        // T4 MEM wait inside MDU_BUSY freezes the busy count; then timeout
        ex_mduStart = 1;
        run_cycle("t4_start", C_NORM);
        ex_mduStart = 0;
        run_cycle("t4_busy1", C_MDU);
        run_cycle("t4_busy2", C_MDU);
        mem_access = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) run_cycle($sformatf("t4_memwait%0d", i), C_MEMW);
        mem_access = 0; dmem_ready = 1;
        for (int i = 3; i < 64; i++) run_cycle($sformatf("t4_busy%0d", i), C_MDU);
        @(negedge clk);
        check("t4_busy64", {25'd0, ctl}, {25'd0, C_MDU});
        check("t4_timeout_before", {31'd0, mdu_timeout}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_busy65", {25'd0, ctl}, {25'd0, C_MDU});
        check("t4_timeout_set", {31'd0, mdu_timeout}, 32'd1);
        @(posedge clk);
        #1;

        // T6 asynchronous reset mid-cycle while still MDU_BUSY
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_ctl", {25'd0, ctl}, {25'd0, C_RESET});
        check("t6_async_timeout", {31'd0, mdu_timeout}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycle("t6_run", C_NORM);
        check("t6_timeout_clear", {31'd0, mdu_timeout}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("t6_stall_cnt", stall_cycles, 32'd0);
        check("t6_flush_cnt", flush_events, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
